mac_operand_serializer: RTL and testbench

//  Upstream feeder for the bit-serial MAC (O = A*B + C).
//  - Accepts one parallel operand set {a, b, c} through a valid/ready handshake.
//  - Serializes the set LSB-first onto the MAC's A/B/C inputs.
//  - Issues the one-cycle START pulse aligned with bit 0.
//  - Paces itself on the MAC's READY/END status.
//  - A one-entry holding register lets the next operand set load while the current one shifts.

---
 rtl/mac_operand_serializer_pkg.sv | 13 +
 rtl/mac_operand_serializer_piso_shreg.sv | 36 +++
 rtl/mac_operand_serializer.sv | 139 +++++++++++++
 tb/tb_mac_operand_serializer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_operand_serializer_pkg.sv
// Shared definitions for the bit-serial MAC, its operand serializer and
// its result deserializer.
package mac_operand_serializer_pkg;

   localparam int unsigned MAC_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SHIFT    = 2'd1,
      ST_WAIT_END = 2'd2
   } mac_state_e;

endpackage

// File: rtl/mac_operand_serializer_piso_shreg.sv
// Parallel-load, right-shift register; LSB out, zeros shifted in at
// the top so the line idles low once the word is exhausted.
module mac_operand_serializer_piso_shreg #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             dout
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d = din;
      end else if (shift) begin
         data_d = {1'b0, data_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign dout = data_q[0];

endmodule

// File: rtl/mac_operand_serializer.sv
// Feeds one {a, b, c} operand set at a time to the bit-serial MAC,
// LSB first, with a one-entry holding register in front.
module mac_operand_serializer
   import mac_operand_serializer_pkg::*;
#(
   parameter  int unsigned W  = MAC_W,
   localparam int unsigned CW = 2 * W
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [W-1:0]  IN_A,
   input  logic [W-1:0]  IN_B,
   input  logic [CW-1:0] IN_C,
   input  logic          MAC_READY,
   input  logic          MAC_END,
   output logic          START,
   output logic          A,
   output logic          B,
   output logic          C,
   output logic          BUSY
);

   localparam int unsigned CNT_W = $clog2(CW);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CW - 1);

   mac_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hold_full_q, hold_full_d;
   logic [W-1:0]     hold_a_q, hold_a_d;
   logic [W-1:0]     hold_b_q, hold_b_d;
   logic [CW-1:0]    hold_c_q, hold_c_d;
   logic             start_q, start_d;
   logic             load;
   logic             accept;
   logic             shift_en;

   always_comb begin
      load     = (state_q == ST_IDLE) && hold_full_q && MAC_READY;
      IN_READY = !hold_full_q || load;
      accept   = IN_VALID && IN_READY;
      shift_en = (state_q == ST_SHIFT);

      hold_full_d = hold_full_q;
      hold_a_d    = hold_a_q;
      hold_b_d    = hold_b_q;
      hold_c_d    = hold_c_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      start_d     = 1'b0;

      // a set arriving on the load edge refills the slot being drained
      if (accept) begin
         hold_full_d = 1'b1;
         hold_a_d    = IN_A;
         hold_b_d    = IN_B;
         hold_c_d    = IN_C;
      end else if (load) begin
         hold_full_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               start_d = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_WAIT_END;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_END: begin
            if (MAC_END) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         hold_full_q <= 1'b0;
         hold_a_q    <= '0;
         hold_b_q    <= '0;
         hold_c_q    <= '0;
         start_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_full_q <= hold_full_d;
         hold_a_q    <= hold_a_d;
         hold_b_q    <= hold_b_d;
         hold_c_q    <= hold_c_d;
         start_q     <= start_d;
      end
   end

   mac_operand_serializer_piso_shreg #(.WIDTH(W)) u_sh_a (
      .clk   (CLK),
      .rst_n (RST),
      .load  (load),
      .shift (shift_en),
      .din   (hold_a_q),
      .dout  (A)
   );

   mac_operand_serializer_piso_shreg #(.WIDTH(W)) u_sh_b (
      .clk   (CLK),
      .rst_n (RST),
      .load  (load),
      .shift (shift_en),
      .din   (hold_b_q),
      .dout  (B)
   );

   mac_operand_serializer_piso_shreg #(.WIDTH(CW)) u_sh_c (
      .clk   (CLK),
      .rst_n (RST),
      .load  (load),
      .shift (shift_en),
      .din   (hold_c_q),
      .dout  (C)
   );

   assign START = start_q;
   assign BUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mac_operand_serializer.sv
// Bench for mac_operand_serializer: scoreboard of accepted sets checked
// bit by bit against the serial stream, plus directed timing cases.
module tb_mac_operand_serializer;
   import mac_operand_serializer_pkg::*;

   localparam int W       = MAC_W;
   localparam int CW      = 2 * W;
   localparam int END_LAT = 2;

   logic          CLK       = 1'b0;
   logic          RST       = 1'b0;
   logic          IN_VALID  = 1'b0;
   logic [W-1:0]  IN_A      = '0;
   logic [W-1:0]  IN_B      = '0;
   logic [CW-1:0] IN_C      = '0;
   logic          MAC_READY = 1'b0;
   logic          MAC_END   = 1'b0;
   logic          IN_READY;
   logic          START;
   logic          A;
   logic          B;
   logic          C;
   logic          BUSY;

   mac_operand_serializer dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_A      (IN_A),
      .IN_B      (IN_B),
      .IN_C      (IN_C),
      .MAC_READY (MAC_READY),
      .MAC_END   (MAC_END),
      .START     (START),
      .A         (A),
      .B         (B),
      .C         (C),
      .BUSY      (BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [CW-1:0] c;
   } opset_t;

   opset_t exp_q[$];
   opset_t cur;
   int     n_chk       = 0;
   int     n_pass      = 0;
   int     bitpos      = -1;
   bit     waiting     = 1'b0;
   int     cyc         = 0;
   int     last_end    = 0;
   bit     gap_arm     = 1'b0;
   bit     gap_pending = 1'b0;
   int     done_cnt    = 0;
   bit     stray_req   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                    tag, got, exp, $time);
   endtask

   // stream monitor / scoreboard
   always @(negedge CLK) begin : mon
      int pre;
      cyc++;
      if (!RST) begin
         exp_q.delete();
         bitpos      = -1;
         waiting     = 1'b0;
         gap_pending = 1'b0;
         chk("rst_out", {27'd0, START, A, B, C, BUSY}, 32'd0);
      end else begin
         pre = bitpos;
         if (!gap_arm) gap_pending = 1'b0;
         if (pre < 0) begin
            if (START) begin
               if (exp_q.size() == 0) begin
                  chk("start_unexp", {31'd0, START}, 32'd0);
               end else begin
                  cur     = exp_q.pop_front();
                  bitpos  = 0;
                  waiting = 1'b1;
                  if (gap_pending) begin
                     chk("end_to_start", cyc - last_end, 32'd2);
                     gap_pending = 1'b0;
                  end
               end
            end else begin
               chk("idle_abc", {29'd0, A, B, C}, 32'd0);
            end
         end
         if (bitpos >= 0) begin
            chk("start", {31'd0, START}, {31'd0, bitpos == 0});
            chk("a", {31'd0, A},
                {31'd0, (bitpos < W) ? cur.a[bitpos] : 1'b0});
            chk("b", {31'd0, B},
                {31'd0, (bitpos < W) ? cur.b[bitpos] : 1'b0});
            chk("c", {31'd0, C}, {31'd0, cur.c[bitpos]});
            bitpos++;
            if (bitpos == CW) begin
               bitpos = -1;
               done_cnt++;
            end
         end
         chk("busy", {31'd0, BUSY}, {31'd0, waiting});
         if (waiting && pre < 0 && bitpos < 0 && MAC_END) begin
            waiting  = 1'b0;
            last_end = cyc;
            if (gap_arm) gap_pending = 1'b1;
         end
      end
   end

   // MAC stand-in: END pulse a fixed time after the last serial bit
   always @(posedge CLK) begin : mac
      int seen;
      int countdown;
      #1;
      MAC_END = 1'b0;
      if (!RST) begin
         countdown = 0;
         seen      = done_cnt;
      end else begin
         if (done_cnt != seen) begin
            seen      = done_cnt;
            countdown = END_LAT;
         end
         if (countdown > 0) begin
            countdown--;
            if (countdown == 0) MAC_END = 1'b1;
         end
         if (stray_req) MAC_END = 1'b1;
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [CW-1:0] c, input bit stall);
      bit ok;
      ok = 1'b0;
      @(posedge CLK);
      #1;
      IN_VALID = 1'b1;
      IN_A     = a;
      IN_B     = b;
      IN_C     = c;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (stall && i == 0) chk("in_ready_stall", {31'd0, IN_READY}, 32'd0);
         if (IN_READY) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) exp_q.push_back({a, b, c});
      else chk("accept_timeout", 32'd0, 32'd1);
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK);
         #2;
         if (exp_q.size() == 0 && bitpos < 0 && !waiting) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      bit ok;
      RST       = 1'b0;
      MAC_READY = 1'b1;
      repeat (2) @(negedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_start", {31'd0, START}, 32'd0);

      send(4'hF, 4'hF, 8'hFF, 1'b0);
      drain();

      // stray END lands in the first SHIFT cycle and must be ignored
      send(4'b0101, 4'b1010, 8'b0111_0111, 1'b0);
      @(negedge CLK);
      stray_req = 1'b1;
      @(negedge CLK);
      stray_req = 1'b0;
      drain();

      @(posedge CLK);
      #1;
      MAC_READY = 1'b0;
      send(4'h9, 4'h6, 8'hC3, 1'b0);
      repeat (5) begin
         @(negedge CLK);
         chk("stall_start", {31'd0, START}, 32'd0);
         chk("stall_in_ready", {31'd0, IN_READY}, 32'd0);
      end
      @(posedge CLK);
      #1;
      MAC_READY = 1'b1;
      @(negedge CLK);
      chk("mr_start_1st", {31'd0, START}, 32'd0);
      @(negedge CLK);
      chk("mr_start_2nd", {31'd0, START}, 32'd1);
      drain();

      gap_arm = 1'b1;
      send(4'h3, 4'hE, 8'h5A, 1'b0);
      send(4'hA, 4'h1, 8'h81, 1'b0);
      send(4'h7, 4'h8, 8'hF0, 1'b1);
      drain();
      gap_arm = 1'b0;

      send(4'hF, 4'hF, 8'hFF, 1'b0);
      send(4'h2, 4'h4, 8'h18, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         #2;
         if (bitpos == 3) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("cnt3_timeout", 32'd0, 32'd1);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      #1;
      chk("rst_async", {27'd0, START, A, B, C, BUSY}, 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      @(negedge CLK);
      chk("post_rst_ready", {31'd0, IN_READY}, 32'd1);
      repeat (20) @(negedge CLK);
      chk("post_rst_busy", {31'd0, BUSY}, 32'd0);

      @(negedge CLK);
      stray_req = 1'b1;
      @(negedge CLK);
      stray_req = 1'b0;
      repeat (3) @(negedge CLK);
      chk("stray_idle_busy", {31'd0, BUSY}, 32'd0);
      chk("stray_idle_ready", {31'd0, IN_READY}, 32'd1);

      send(4'h3, 4'hC, 8'hA5, 1'b0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
